// File: rtl/multichannel_position_to_meter.sv
// ---------------------------------------------------------------------------
// multichannel_position_to_meter : N-channel position to bar/dot meter bitmap with peak hold and fall
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multichannel_position_to_meter #(
   parameter  int WIDTH           = 32,
   parameter  int CHANNELS        = 2,
   parameter  int PEAK_HOLD_COUNT = 1000,
   parameter  int PEAK_FALL_DIV   = 4,
   localparam int CW              = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int PW              = $clog2(WIDTH)
) (
   input  logic             reset,
   input  logic             clk,
   input  logic             i_valid,
   output logic             i_ready,
   input  logic [CW-1:0]    i_channel,
   input  logic [PW-1:0]    i_position,
   input  logic             i_dot_mode,
   input  logic             i_clear,
   output logic             o_valid,
   input  logic             o_ready,
   output logic [CW-1:0]    o_channel,
   output logic [WIDTH-1:0] o_meter,
   output logic [PW-1:0]    o_peak
);

   localparam int HW = (PEAK_HOLD_COUNT > 0) ? $clog2(PEAK_HOLD_COUNT + 1) : 1;
   localparam int FW = $clog2(PEAK_FALL_DIV + 1);

   localparam logic [PW-1:0] POS_MAX   = PW'(WIDTH - 1);
   localparam logic [HW-1:0] HOLD_INIT = HW'(PEAK_HOLD_COUNT);
   localparam logic [FW-1:0] FALL_LAST = FW'(PEAK_FALL_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RENDER = 2'd1,
      S_OUTPUT = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [PW-1:0]    peak_q [CHANNELS];
   logic [HW-1:0]    hold_q [CHANNELS];
   logic [FW-1:0]    fall_q [CHANNELS];

   logic [PW-1:0]    pos_q;
   logic [PW-1:0]    k_q;
   logic             dot_q;
   logic [PW-1:0]    rpeak_q;
   logic [CW-1:0]    chan_q;
   logic [WIDTH-1:0] meter_q;
   logic             valid_q;

   logic             w_accept;
   logic             w_chan_ok;
   logic             w_take;
   logic [PW-1:0]    w_pos;
   logic [PW-1:0]    w_cur_peak;
   logic [HW-1:0]    w_cur_hold;
   logic [FW-1:0]    w_cur_fall;
   logic [PW-1:0]    w_upd_peak;
   logic [HW-1:0]    w_upd_hold;
   logic [FW-1:0]    w_upd_fall;
   logic [PW-1:0]    w_render_peak;
   logic             w_lit;

   assign w_accept  = i_valid && (state_q == S_IDLE);
   assign w_chan_ok = 32'(i_channel) < 32'(CHANNELS);
   assign w_take    = w_accept && w_chan_ok;
   assign w_pos     = (32'(i_position) > 32'(WIDTH - 1)) ? POS_MAX : i_position;

   always_comb begin
      w_cur_peak = '0;
      w_cur_hold = '0;
      w_cur_fall = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (32'(i_channel) == 32'(c)) begin
            w_cur_peak = peak_q[c];
            w_cur_hold = hold_q[c];
            w_cur_fall = fall_q[c];
         end
      end
   end

   // Peak decay: hold countdown first, then one segment per PEAK_FALL_DIV samples.
   always_comb begin
      w_upd_peak = w_cur_peak;
      w_upd_hold = w_cur_hold;
      w_upd_fall = w_cur_fall;
      if (w_pos >= w_cur_peak) begin
         w_upd_peak = w_pos;
         w_upd_hold = HOLD_INIT;
         w_upd_fall = '0;
      end else if (w_cur_hold != '0) begin
         w_upd_hold = w_cur_hold - HW'(1);
      end else if (w_cur_fall == FALL_LAST) begin
         w_upd_peak = w_cur_peak - PW'(1);
         w_upd_fall = '0;
      end else begin
         w_upd_fall = w_cur_fall + FW'(1);
      end
   end

   assign w_render_peak = i_clear ? w_pos : w_upd_peak;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < CHANNELS; c++) begin
            peak_q[c] <= '0;
            hold_q[c] <= '0;
            fall_q[c] <= '0;
         end
      end else if (i_clear) begin
         for (int c = 0; c < CHANNELS; c++) begin
            peak_q[c] <= '0;
            hold_q[c] <= '0;
            fall_q[c] <= '0;
         end
      end else if (w_take) begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (32'(i_channel) == 32'(c)) begin
               peak_q[c] <= w_upd_peak;
               hold_q[c] <= w_upd_hold;
               fall_q[c] <= w_upd_fall;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      i_ready = 1'b0;
      case (state_q)
         S_IDLE: begin
            i_ready = 1'b1;
            if (w_take) begin
               state_d = S_RENDER;
            end
         end
         S_RENDER: begin
            if (k_q == POS_MAX) begin
               state_d = S_OUTPUT;
            end
         end
         S_OUTPUT: begin
            if (valid_q && o_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign w_lit = (k_q == rpeak_q) | (dot_q ? (k_q == pos_q) : (k_q <= pos_q));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pos_q   <= '0;
         k_q     <= '0;
         dot_q   <= 1'b0;
         rpeak_q <= '0;
         chan_q  <= '0;
         meter_q <= '0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (w_take) begin
                  pos_q   <= w_pos;
                  dot_q   <= i_dot_mode;
                  chan_q  <= i_channel;
                  rpeak_q <= w_render_peak;
                  k_q     <= '0;
               end
            end
            S_RENDER: begin
               meter_q <= {w_lit, meter_q[WIDTH-1:1]};
               k_q     <= k_q + PW'(1);
            end
            S_OUTPUT: begin
               // First OUTPUT cycle raises valid; it then holds until the handshake.
               if (!valid_q) begin
                  valid_q <= 1'b1;
               end else if (o_ready) begin
                  valid_q <= 1'b0;
               end
            end
            default: valid_q <= 1'b0;
         endcase
      end
   end

   assign o_valid   = valid_q;
   assign o_channel = chan_q;
   assign o_meter   = meter_q;
   assign o_peak    = rpeak_q;

endmodule

`default_nettype wire

// File: tb/tb_multichannel_position_to_meter.sv
// ---------------------------------------------------------------------------
// tb_multichannel_position_to_meter : directed bench for the multichannel meter (WIDTH=8)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_multichannel_position_to_meter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;

   logic       i_valid = 1'b0;
   logic       i_ready;
   logic [0:0] i_channel = '0;
   logic [2:0] i_position = '0;
   logic       i_dot_mode = 1'b0;
   logic       i_clear = 1'b0;
   logic       o_valid;
   logic       o_ready = 1'b1;
   logic [0:0] o_channel;
   logic [7:0] o_meter;
   logic [2:0] o_peak;

   logic       v3 = 1'b0;
   logic       rdy3;
   logic [1:0] ch3 = '0;
   logic [2:0] pos3 = '0;
   logic       ov3;
   logic [1:0] och3;
   logic [7:0] om3;
   logic [2:0] opk3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multichannel_position_to_meter #(
      .WIDTH(8), .CHANNELS(2), .PEAK_HOLD_COUNT(3), .PEAK_FALL_DIV(2)
   ) dut (
      .reset(reset), .clk(clk),
      .i_valid(i_valid), .i_ready(i_ready), .i_channel(i_channel),
      .i_position(i_position), .i_dot_mode(i_dot_mode), .i_clear(i_clear),
      .o_valid(o_valid), .o_ready(o_ready), .o_channel(o_channel),
      .o_meter(o_meter), .o_peak(o_peak)
   );

   multichannel_position_to_meter #(
      .WIDTH(8), .CHANNELS(3), .PEAK_HOLD_COUNT(3), .PEAK_FALL_DIV(2)
   ) dut3 (
      .reset(reset), .clk(clk),
      .i_valid(v3), .i_ready(rdy3), .i_channel(ch3),
      .i_position(pos3), .i_dot_mode(1'b0), .i_clear(1'b0),
      .o_valid(ov3), .o_ready(1'b1), .o_channel(och3),
      .o_meter(om3), .o_peak(opk3)
   );

   // Stimulus only: sends one sample, returns latency (-1 on timeout) and captured outputs.
   task automatic do_sample(input logic [0:0] ch, input logic [2:0] pos, input logic dot,
                            input logic clr, output int lat, output logic [7:0] meter,
                            output logic [2:0] peak, output logic [0:0] chan);
      @(negedge clk);
      i_valid = 1'b1; i_channel = ch; i_position = pos; i_dot_mode = dot; i_clear = clr;
      @(posedge clk); #1;
      i_valid = 1'b0; i_clear = 1'b0;
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (o_valid) begin
            lat = n;
            break;
         end
      end
      meter = o_meter; peak = o_peak; chan = o_channel;
      if (lat > 0) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic do_clear();
      @(negedge clk); i_clear = 1'b1;
      @(negedge clk); i_clear = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if (o_valid !== 1'b0 || i_ready !== 1'b1 || o_meter !== 8'h00 || o_peak !== 3'd0 || o_channel !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: v=%b rdy=%b meter=%b peak=%0d ch=%0d required v=0 rdy=1 meter=0 peak=0 ch=0",
                  o_valid, i_ready, o_meter, o_peak, o_channel);
      end
   endtask

   task automatic test_bar_basic();
      int lat; logic [7:0] m; logic [2:0] p; logic [0:0] c;
      do_sample(1'b0, 3'd5, 1'b0, 1'b0, lat, m, p, c);
      checks++;
      if (lat !== 9) begin errors++; $display("FAIL bar_latency: got %0d required 9", lat); end
      checks++;
      if (m !== 8'b0011_1111) begin errors++; $display("FAIL bar_meter: got %b required 00111111", m); end
      checks++;
      if (p !== 3'd5 || c !== 1'b0) begin errors++; $display("FAIL bar_peak_ch: got peak %0d ch %0d required 5 0", p, c); end
      checks++;
      if (o_valid !== 1'b0 || i_ready !== 1'b1) begin
         errors++; $display("FAIL bar_handshake: got v=%b rdy=%b required v=0 rdy=1", o_valid, i_ready);
      end
   endtask

   task automatic test_peak_fall();
      int lat; logic [7:0] m; logic [2:0] p; logic [0:0] c;
      logic [2:0] exp_pk [6];
      exp_pk[0] = 3'd5; exp_pk[1] = 3'd5; exp_pk[2] = 3'd5;
      exp_pk[3] = 3'd5; exp_pk[4] = 3'd5; exp_pk[5] = 3'd4;
      do_clear();
      for (int i = 0; i < 6; i++) begin
         do_sample(1'b0, (i == 0) ? 3'd5 : 3'd2, 1'b0, 1'b0, lat, m, p, c);
         checks++;
         if (p !== exp_pk[i]) begin errors++; $display("FAIL fall_peak[%0d]: got %0d required %0d", i, p, exp_pk[i]); end
      end
      checks++;
      if (m !== 8'b0001_0111) begin errors++; $display("FAIL fall_meter: got %b required 00010111", m); end
   endtask

   task automatic test_channels();
      int lat; logic [7:0] m; logic [2:0] p; logic [0:0] c;
      do_clear();
      do_sample(1'b0, 3'd7, 1'b0, 1'b0, lat, m, p, c);
      do_sample(1'b1, 3'd1, 1'b0, 1'b0, lat, m, p, c);
      checks++;
      if (m !== 8'b0000_0011 || p !== 3'd1 || c !== 1'b1) begin
         errors++; $display("FAIL ch1_result: got meter %b peak %0d ch %0d required 00000011 1 1", m, p, c);
      end
      do_sample(1'b0, 3'd0, 1'b0, 1'b0, lat, m, p, c);
      checks++;
      if (m !== 8'b1000_0001 || p !== 3'd7 || c !== 1'b0) begin
         errors++; $display("FAIL ch0_kept: got meter %b peak %0d ch %0d required 10000001 7 0", m, p, c);
      end
   endtask

   task automatic test_dot_mode();
      int lat; logic [7:0] m; logic [2:0] p; logic [0:0] c;
      do_clear();
      do_sample(1'b0, 3'd6, 1'b0, 1'b0, lat, m, p, c);
      do_sample(1'b0, 3'd3, 1'b1, 1'b0, lat, m, p, c);
      checks++;
      if (m !== 8'b0100_1000 || p !== 3'd6) begin
         errors++; $display("FAIL dot_meter: got %b peak %0d required 01001000 6", m, p);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] m0; logic [2:0] p0; bit seen;
      do_clear();
      @(negedge clk);
      o_ready = 1'b0;
      i_valid = 1'b1; i_channel = 1'b1; i_position = 3'd4; i_dot_mode = 1'b0;
      @(posedge clk); #1;
      i_valid = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 40 && !seen; n++) begin
         @(posedge clk); #1;
         seen = o_valid;
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL bp_valid_timeout: got o_valid 0 required 1"); end
      m0 = o_meter; p0 = o_peak;
      checks++;
      if (m0 !== 8'b0001_1111 || p0 !== 3'd4) begin
         errors++; $display("FAIL bp_result: got %b peak %0d required 00011111 4", m0, p0);
      end
      for (int n = 0; n < 10; n++) begin
         @(posedge clk); #1;
         checks++;
         if (o_valid !== 1'b1 || i_ready !== 1'b0 || o_meter !== m0 || o_peak !== p0 || o_channel !== 1'b1) begin
            errors++; $display("FAIL bp_hold[%0d]: got v=%b rdy=%b meter=%b peak=%0d ch=%0d", n, o_valid, i_ready, o_meter, o_peak, o_channel);
         end
      end
      @(negedge clk); o_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (o_valid !== 1'b0 || i_ready !== 1'b1) begin
         errors++; $display("FAIL bp_release: got v=%b rdy=%b required v=0 rdy=1", o_valid, i_ready);
      end
   endtask

   task automatic test_clear_on_accept();
      int lat; logic [7:0] m; logic [2:0] p; logic [0:0] c;
      do_clear();
      do_sample(1'b0, 3'd7, 1'b0, 1'b0, lat, m, p, c);
      do_sample(1'b0, 3'd3, 1'b0, 1'b1, lat, m, p, c);
      checks++;
      if (m !== 8'b0000_1111 || p !== 3'd3) begin
         errors++; $display("FAIL clear_accept: got %b peak %0d required 00001111 3", m, p);
      end
      do_sample(1'b0, 3'd1, 1'b0, 1'b0, lat, m, p, c);
      checks++;
      if (m !== 8'b0000_0011 || p !== 3'd1) begin
         errors++; $display("FAIL clear_after: got %b peak %0d required 00000011 1", m, p);
      end
   endtask

   task automatic test_invalid_channel();
      bit seen; bit rdy_low; int lat;
      @(negedge clk);
      v3 = 1'b1; ch3 = 2'd3; pos3 = 3'd4;
      @(posedge clk); #1;
      v3 = 1'b0;
      seen = 1'b0; rdy_low = 1'b0;
      for (int n = 0; n < 15; n++) begin
         if (ov3) seen = 1'b1;
         if (!rdy3) rdy_low = 1'b1;
         @(posedge clk); #1;
      end
      checks++;
      if (seen || rdy_low) begin
         errors++; $display("FAIL invalid_ch_drop: got valid_seen=%b ready_dropped=%b required 0 0", seen, rdy_low);
      end
      @(negedge clk);
      v3 = 1'b1; ch3 = 2'd2; pos3 = 3'd4;
      @(posedge clk); #1;
      v3 = 1'b0;
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (ov3) begin lat = n; break; end
      end
      checks++;
      if (lat !== 9 || om3 !== 8'b0001_1111 || opk3 !== 3'd4 || och3 !== 2'd2) begin
         errors++; $display("FAIL ch2_after_drop: got lat %0d meter %b peak %0d ch %0d required 9 00011111 4 2", lat, om3, opk3, och3);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_render();
      int lat; logic [7:0] m; logic [2:0] p; logic [0:0] c;
      do_sample(1'b1, 3'd6, 1'b0, 1'b0, lat, m, p, c);
      @(negedge clk);
      i_valid = 1'b1; i_channel = 1'b1; i_position = 3'd7; i_dot_mode = 1'b0;
      @(posedge clk); #1;
      i_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      #2;
      checks++;
      if (o_valid !== 1'b0 || i_ready !== 1'b1 || o_meter !== 8'h00 || o_peak !== 3'd0 || o_channel !== 1'b0) begin
         errors++; $display("FAIL reset_mid_render: got v=%b rdy=%b meter=%b peak=%0d ch=%0d required 0 1 0 0 0",
                            o_valid, i_ready, o_meter, o_peak, o_channel);
      end
      @(negedge clk); reset = 1'b0;
      do_sample(1'b1, 3'd2, 1'b0, 1'b0, lat, m, p, c);
      checks++;
      if (lat !== 9 || m !== 8'b0000_0111 || p !== 3'd2) begin
         errors++; $display("FAIL after_reset: got lat %0d meter %b peak %0d required 9 00000111 2", lat, m, p);
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_bar_basic();
      test_peak_fall();
      test_channels();
      test_dot_mode();
      test_backpressure();
      test_clear_on_accept();
      test_invalid_channel();
      test_reset_mid_render();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
